// File: rtl/serializer_pkg.sv
// Shared types and helpers for the flit-to-phit serializer.
package serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam bit ORDER_LSB_FIRST = 1'b0;
    localparam bit ORDER_MSB_FIRST = 1'b1;

    function automatic int unsigned phits_f(input int unsigned flit_w, input int unsigned phit_w);
        return flit_w / phit_w;
    endfunction

    function automatic int unsigned cnt_width_f(input int unsigned phits);
        return (phits > 1) ? $clog2(phits) : 1;
    endfunction

endpackage

// File: rtl/phit_shift_reg.sv
// Load/shift register that presents one phit at its head and moves toward it on each shift.
module phit_shift_reg
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned STEP      = 4,
    parameter bit          MSB_FIRST = ORDER_LSB_FIRST
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic [STEP-1:0]  head
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end else if (shift) begin
            if (MSB_FIRST == ORDER_MSB_FIRST) begin
                data_d = {data_q[WIDTH-STEP-1:0], STEP'(0)};
            end else begin
                data_d = {STEP'(0), data_q[WIDTH-1:STEP]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign head = (MSB_FIRST == ORDER_MSB_FIRST) ? data_q[WIDTH-1 -: STEP] : data_q[STEP-1:0];

endmodule

// File: rtl/flit_serializer.sv
// Pops flits from a FWFT FIFO and streams them as phits over a valid/ready link.
module flit_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH = 32,
    parameter int unsigned PHIT_WIDTH = 4,
    parameter bit          MSB_FIRST  = ORDER_LSB_FIRST
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [FLIT_WIDTH-1:0] fifo_data,
    output logic                  read_fifo,
    output logic [PHIT_WIDTH-1:0] phit_data,
    output logic                  phit_valid,
    input  logic                  phit_ready,
    output logic                  phit_first,
    output logic                  phit_last,
    output logic                  serializer_idle
);

    localparam int unsigned PHITS = phits_f(FLIT_WIDTH, PHIT_WIDTH);
    localparam int unsigned CNT_W = cnt_width_f(PHITS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PHITS - 1);

    if (((FLIT_WIDTH % PHIT_WIDTH) != 0) || (PHITS < 2)) begin : g_param_check
        $error("flit_serializer: FLIT_WIDTH must be a multiple of PHIT_WIDTH giving at least two phits");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             idle_q, idle_d;
    logic             accept;
    logic             at_last;
    logic             load;
    logic             shift_en;

    // Next-state: a pop on the last accepted phit reloads without a bubble.
    always_comb begin
        accept   = valid_q & phit_ready;
        at_last  = (cnt_q == LAST_IDX);
        load     = !reset && !fifo_empty && ((state_q == IDLE) || (accept && at_last));
        shift_en = accept && !at_last;
        state_d  = state_q;
        cnt_d    = cnt_q;

        if (load) begin
            state_d = SHIFT;
            cnt_d   = '0;
        end else if (accept) begin
            if (at_last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        valid_d = (state_d == SHIFT);
        first_d = valid_d && (cnt_d == '0);
        last_d  = valid_d && (cnt_d == LAST_IDX);
        idle_d  = !valid_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
            idle_q  <= idle_d;
        end
    end

    phit_shift_reg #(
        .WIDTH     (FLIT_WIDTH),
        .STEP      (PHIT_WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .shift     (shift_en),
        .load_data (fifo_data),
        .head      (phit_data)
    );

    assign read_fifo       = load;
    assign phit_valid      = valid_q;
    assign phit_first      = first_q;
    assign phit_last       = last_q;
    assign serializer_idle = idle_q;

endmodule

// File: tb/tb_flit_serializer.sv
// Randomized and directed bench for flit_serializer against a phit-stream reference model.
module tb_flit_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data = '0;
    logic        read_fifo;
    logic [3:0]  phit_data;
    logic        phit_valid;
    logic        phit_ready = 1'b0;
    logic        phit_first;
    logic        phit_last;
    logic        serializer_idle;

    logic        m_fifo_empty = 1'b1;
    logic [15:0] m_fifo_data = '0;
    logic        m_read_fifo;
    logic [7:0]  m_phit_data;
    logic        m_phit_valid;
    logic        m_phit_ready = 1'b0;
    logic        m_phit_first;
    logic        m_phit_last;
    logic        m_idle;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] src_q[$];
    logic [5:0]  exp_q[$];

    logic       s_rd, s_valid, s_first, s_last, s_idle, s_ready;
    logic [3:0] s_data;

    always #5 clk = ~clk;

    flit_serializer u_dut (
        .clk             (clk),
        .reset           (reset),
        .fifo_empty      (fifo_empty),
        .fifo_data       (fifo_data),
        .read_fifo       (read_fifo),
        .phit_data       (phit_data),
        .phit_valid      (phit_valid),
        .phit_ready      (phit_ready),
        .phit_first      (phit_first),
        .phit_last       (phit_last),
        .serializer_idle (serializer_idle)
    );

    flit_serializer #(
        .FLIT_WIDTH (16),
        .PHIT_WIDTH (8),
        .MSB_FIRST  (1'b1)
    ) u_mode (
        .clk             (clk),
        .reset           (reset),
        .fifo_empty      (m_fifo_empty),
        .fifo_data       (m_fifo_data),
        .read_fifo       (m_read_fifo),
        .phit_data       (m_phit_data),
        .phit_valid      (m_phit_valid),
        .phit_ready      (m_phit_ready),
        .phit_first      (m_phit_first),
        .phit_last       (m_phit_last),
        .serializer_idle (m_idle)
    );

    // Phit i of a flit, straight from the bit-order rule.
    function automatic logic [31:0] exp_phit(input logic [31:0] flit, input int i,
                                             input int fw, input int pw, input bit msb);
        int sh;
        logic [31:0] mask;
        sh   = msb ? (fw - pw * (i + 1)) : (pw * i);
        mask = (32'h1 << pw) - 32'h1;
        return (flit >> sh) & mask;
    endfunction

    task automatic refresh();
        fifo_empty = (src_q.size() == 0);
        fifo_data  = fifo_empty ? 32'h0 : src_q[0];
    endtask

    task automatic push_flit(input logic [31:0] flit);
        src_q.push_back(flit);
        for (int i = 0; i < 8; i++)
            exp_q.push_back({(i == 0), (i == 7), 4'(exp_phit(flit, i, 32, 4, 1'b0))});
        refresh();
    endtask

    // Sample on the falling edge, then let the rising edge act on the bench FIFO.
    task automatic cycle();
        @(negedge clk);
        s_rd    = read_fifo;
        s_valid = phit_valid;
        s_data  = phit_data;
        s_first = phit_first;
        s_last  = phit_last;
        s_idle  = serializer_idle;
        s_ready = phit_ready;
        @(posedge clk);
        #1;
        if (s_rd && src_q.size() > 0) void'(src_q.pop_front());
        refresh();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        src_q.delete();
        src_q.push_back(32'hDEADBEEF);
        refresh();
        m_fifo_empty = 1'b0;
        phit_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({read_fifo, phit_valid, phit_first, phit_last, serializer_idle} !== 5'b00001)
            $display("FAIL reset_outputs got %b want 00001", {read_fifo, phit_valid, phit_first, phit_last, serializer_idle});
        else pass_cnt++;
        total_cnt++;
        if ({m_read_fifo, m_phit_valid, m_idle} !== 3'b001)
            $display("FAIL reset_mode_outputs got %b want 001", {m_read_fifo, m_phit_valid, m_idle});
        else pass_cnt++;
        m_fifo_empty = 1'b1;
        src_q.delete();
        refresh();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [31:0] f;
        f = 32'h12345678;
        src_q.push_back(f);
        refresh();
        phit_ready = 1'b1;
        cycle();
        total_cnt++;
        if ({s_rd, s_valid} !== 2'b10) $display("FAIL single_pop got %b want 10", {s_rd, s_valid});
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            cycle();
            total_cnt++;
            if ({s_valid, s_first, s_last, s_data} !== {1'b1, (i == 0), (i == 7), 4'(exp_phit(f, i, 32, 4, 1'b0))})
                $display("FAIL single_phit[%0d] got v%b f%b l%b %h want phit %h", i, s_valid, s_first, s_last, s_data,
                         4'(exp_phit(f, i, 32, 4, 1'b0)));
            else pass_cnt++;
        end
        cycle();
        total_cnt++;
        if ({s_valid, s_idle} !== 2'b01) $display("FAIL single_idle got %b want 01", {s_valid, s_idle});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] f;
        src_q.push_back(32'hAAAAAAAA);
        src_q.push_back(32'h55555555);
        refresh();
        phit_ready = 1'b1;
        cycle();
        total_cnt++;
        if (s_rd !== 1'b1) $display("FAIL b2b_first_pop got %b want 1", s_rd);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            cycle();
            f = (i < 8) ? 32'hAAAAAAAA : 32'h55555555;
            total_cnt++;
            if ({s_valid, s_rd, s_data} !== {1'b1, (i == 7), 4'(exp_phit(f, i % 8, 32, 4, 1'b0))})
                $display("FAIL b2b_phit[%0d] got v%b rd%b %h want rd%b %h", i, s_valid, s_rd, s_data, (i == 7),
                         4'(exp_phit(f, i % 8, 32, 4, 1'b0)));
            else pass_cnt++;
        end
        cycle();
        total_cnt++;
        if ({s_valid, s_idle} !== 2'b01) $display("FAIL b2b_idle got %b want 01", {s_valid, s_idle});
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] f;
        f = 32'h12345678;
        src_q.push_back(f);
        src_q.push_back(32'hCAFEF00D);
        refresh();
        phit_ready = 1'b1;
        cycle();
        for (int i = 0; i < 3; i++) cycle();
        phit_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            total_cnt++;
            if ({s_valid, s_rd, s_data} !== {1'b1, 1'b0, 4'h5})
                $display("FAIL bp_hold[%0d] got v%b rd%b %h want v1 rd0 5", k, s_valid, s_rd, s_data);
            else pass_cnt++;
        end
        phit_ready = 1'b1;
        for (int i = 3; i < 7; i++) begin
            cycle();
            total_cnt++;
            if ({s_valid, s_data} !== {1'b1, 4'(exp_phit(f, i, 32, 4, 1'b0))})
                $display("FAIL bp_resume[%0d] got v%b %h want %h", i, s_valid, s_data, 4'(exp_phit(f, i, 32, 4, 1'b0)));
            else pass_cnt++;
        end
        // Stall on the last phit while the next flit waits: no pop until accepted.
        phit_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            total_cnt++;
            if ({s_valid, s_last, s_rd, s_data} !== {1'b1, 1'b1, 1'b0, 4'h1})
                $display("FAIL bp_last_hold[%0d] got v%b l%b rd%b %h want v1 l1 rd0 1", k, s_valid, s_last, s_rd, s_data);
            else pass_cnt++;
        end
        phit_ready = 1'b1;
        cycle();
        total_cnt++;
        if ({s_rd, s_data} !== {1'b1, 4'h1}) $display("FAIL bp_last_pop got rd%b %h want rd1 1", s_rd, s_data);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) cycle();
        cycle();
        total_cnt++;
        if ({s_valid, s_idle} !== 2'b01) $display("FAIL bp_idle got %b want 01", {s_valid, s_idle});
        else pass_cnt++;
    endtask

    task automatic test_mode();
        logic [15:0] f;
        f = 16'hBEEF;
        m_fifo_data  = f;
        m_fifo_empty = 1'b0;
        m_phit_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({m_read_fifo, m_phit_valid} !== 2'b10) $display("FAIL mode_pop got %b want 10", {m_read_fifo, m_phit_valid});
        else pass_cnt++;
        @(posedge clk);
        #1;
        m_fifo_empty = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({m_phit_valid, m_phit_first, m_phit_last, m_phit_data} !==
                {1'b1, (i == 0), (i == 1), 8'(exp_phit({16'h0, f}, i, 16, 8, 1'b1))})
                $display("FAIL mode_phit[%0d] got v%b f%b l%b %h want %h", i, m_phit_valid, m_phit_first, m_phit_last,
                         m_phit_data, 8'(exp_phit({16'h0, f}, i, 16, 8, 1'b1)));
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if ({m_phit_valid, m_idle} !== 2'b01) $display("FAIL mode_idle got %b want 01", {m_phit_valid, m_idle});
        else pass_cnt++;
        m_phit_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] b;
        b = $urandom;
        src_q.push_back(32'h12345678);
        src_q.push_back(b);
        refresh();
        phit_ready = 1'b1;
        cycle();
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({read_fifo, phit_valid, phit_first, phit_last, serializer_idle, phit_data} !== {5'b00001, 4'h0})
            $display("FAIL midreset_outputs got %b %h want 00001 0",
                     {read_fifo, phit_valid, phit_first, phit_last, serializer_idle}, phit_data);
        else pass_cnt++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle();
        total_cnt++;
        if ({s_rd, s_valid} !== 2'b10) $display("FAIL midreset_pop got %b want 10", {s_rd, s_valid});
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            cycle();
            total_cnt++;
            if ({s_valid, s_first, s_last, s_data} !== {1'b1, (i == 0), (i == 7), 4'(exp_phit(b, i, 32, 4, 1'b0))})
                $display("FAIL midreset_phit[%0d] got v%b f%b l%b %h want %h", i, s_valid, s_first, s_last, s_data,
                         4'(exp_phit(b, i, 32, 4, 1'b0)));
            else pass_cnt++;
        end
        cycle();
        total_cnt++;
        if ({s_valid, s_idle} !== 2'b01) $display("FAIL midreset_idle got %b want 01", {s_valid, s_idle});
        else pass_cnt++;
    endtask

    task automatic test_random();
        int pushed;
        int cyc;
        logic prev_stall;
        logic [5:0] prev_phit;
        logic [5:0] e;
        pushed = 0;
        prev_stall = 1'b0;
        prev_phit = '0;
        exp_q.delete();
        for (cyc = 0; cyc < 3000; cyc++) begin
            if (pushed == 40 && exp_q.size() == 0 && src_q.size() == 0) break;
            if (pushed < 40 && $urandom_range(0, 3) == 0) begin
                push_flit($urandom);
                pushed++;
            end
            phit_ready = ($urandom_range(0, 9) < 7);
            cycle();
            if (prev_stall) begin
                total_cnt++;
                if ({s_valid, s_first, s_last, s_data} !== {1'b1, prev_phit})
                    $display("FAIL rand_stall_hold got v%b %b want v1 %b", s_valid, {s_first, s_last, s_data}, prev_phit);
                else pass_cnt++;
            end
            prev_stall = s_valid && !s_ready;
            prev_phit  = {s_first, s_last, s_data};
            if (s_valid && s_ready) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL rand_extra_phit got %b want none", {s_first, s_last, s_data});
                end else begin
                    e = exp_q.pop_front();
                    if ({s_first, s_last, s_data} !== e)
                        $display("FAIL rand_phit got %b want %b", {s_first, s_last, s_data}, e);
                    else pass_cnt++;
                end
            end
        end
        total_cnt++;
        if (exp_q.size() != 0 || pushed != 40)
            $display("FAIL rand_drain got %0d phits left want 0", exp_q.size());
        else pass_cnt++;
        phit_ready = 1'b1;
        cycle();
        total_cnt++;
        if ({s_valid, s_idle} !== 2'b01) $display("FAIL rand_idle got %b want 01", {s_valid, s_idle});
        else pass_cnt++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_mode();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
